uart_rx_fifo_writer: RTL and testbench
======================================

Name: uart_rx_fifo_writer

Overview:
- Asynchronous serial receiver: 8N1 (optional parity), LSB first, line idles high.
- Oversamples the line, deserialises each frame and pushes the byte into the single-clock byte FIFO through its write-enable/data interface.
- Sits between an input pin and the FIFO, on the receive side of the existing FIFO-to-UART-transmit path.
- Flags framing and overrun conditions.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be an even number ≥ 4.

Ports:
- clk  in  1  oversampling clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- line  in  1  serial input, asynchronous to clk, idle high.
- fifo_full  in  1  FIFO Full flag.
- err_clr  in  1  synchronous clear of the sticky error flags.
- fifo_wren  out  1  FIFO WrEn, single-cycle pulse.
- fifo_din  out  8  FIFO Data.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; a good byte was dropped because the FIFO was full.
- parity_err  out  1  sticky; tied 0 without PARITY_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - fifo_wren = 0, fifo_din = 0x00, busy = 0.
  - frame_err, overrun and parity_err = 0.
  - Both synchroniser flops = 1. FSM = IDLE, counters = 0.
  - Reset asserted mid-frame abandons the frame; no write occurs.
- Synchroniser: 2 flops on line. "rxs" is the synchronised value. All decisions use rxs.
- Counters:
  - tick: counts 0..CLKS_PER_BIT-1.
  - bitn: 3 bits, data bit index.
- States:
  - IDLE:
    - rxs = 0 → START, tick = 0. This cycle is t0.
  - START:
    - At tick = CLKS_PER_BIT/2-1, sample rxs.
    - Sample 1 → IDLE; treated as a glitch, no flag.
    - Sample 0 → DATA, tick = 0, bitn = 0.
    - All samples from here are at bit centre.
  - DATA:
    - At tick = CLKS_PER_BIT-1, shift rxs into bit[bitn] (LSB first) and restart tick.
    - After bitn = 7 → STOP (or PARITY when compiled in).
  - STOP:
    - At tick = CLKS_PER_BIT-1, sample.
    - Sample 1, fifo_full = 0: next cycle fifo_wren = 1 for exactly one cycle, fifo_din = byte; → IDLE.
    - Sample 1, fifo_full = 1: no write; overrun ← 1; → IDLE.
    - Sample 0: no write; frame_err ← 1; → BREAK.
  - BREAK:
    - Wait for rxs = 1, then → IDLE.
    - Prevents a held-low line from retriggering.
- Timing, CLKS_PER_BIT = 16:
  - Data bit i is sampled at t0+8+16(i+1).
  - Stop bit is sampled at t0+152.
  - fifo_wren is high at t0+153.
  - Earliest next start detection is t0+153. Back-to-back frames are accepted.
- fifo_din is updated only on a write and holds its value between writes.
- fifo_full is sampled in the same cycle as the stop sample. A full that deasserts later does not recover the byte.
- Sticky flags:
  - err_clr = 1 clears all flags.
  - If a set event coincides with err_clr, the set wins.
- A priority note for the parity build is given under Optional Feature.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA: one bit time, sampled at tick = CLKS_PER_BIT-1.
  - Even parity is expected, i.e. XOR of the 8 data bits and the parity bit = 0.
  - Mismatch: parity_err ← 1 and the byte is dropped, but the FSM still proceeds to STOP.
  - In STOP, frame_err takes priority and a failed-parity byte never writes.
  - Timing shifts by CLKS_PER_BIT: wren at t0+169.
- Undefined: no PARITY state; parity_err constant 0.

Test Plan:
- Reset mid-data, then release → all outputs 0; the next clean frame 0x3C writes 0x3C exactly once.
- Frame 0xA5, fifo_full = 0, CLKS_PER_BIT = 16 → fifo_wren high exactly one cycle at t0+153 with fifo_din = 0xA5; busy falls the same cycle; no flags.
- Two back-to-back frames 0x00 then 0xFF with no idle gap → two wren pulses 160 cycles apart, data 0x00 then 0xFF.
- 3-cycle low glitch on idle line → START aborts to IDLE; no wren, no flags. Then stop bit forced low on frame 0x55 → no wren, frame_err = 1. Line held low 40 bit-times then released → stays in BREAK, no new frame. err_clr pulse → frame_err = 0.
- Frame 0x81 with fifo_full = 1 at the stop sample → no wren, overrun = 1, fifo_din retains its previous value.
- UART_RX_PARITY_EN: frame 0x07 with parity bit 1 → write 0x07. Same frame with parity bit 0 → no write, parity_err = 1.

Source files
------------

// File: rtl/uart_rx_fifo_writer.sv
// rtl/uart_rx_fifo_writer.sv - oversampling 8N1 UART receiver that pushes bytes into a byte FIFO
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo_writer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line,
    input  logic       fifo_full,
    input  logic       err_clr,
    output logic       fifo_wren,
    output logic [7:0] fifo_din,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            wren_q, wren_d;
    logic [7:0]      din_q, din_d;
    logic            fe_q, fe_d;
    logic            ov_q, ov_d;
    logic            set_fe, set_ov;
    logic            rxs;

`ifdef UART_RX_PARITY_EN
    logic            pe_q, pe_d;
    logic            par_bad_q, par_bad_d;
    logic            set_pe;
`endif

    assign rxs = sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
            wren_q  <= 1'b0;
            din_q   <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync1_q <= line;
            sync2_q <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
            wren_q  <= wren_d;
            din_q   <= din_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TW'(1);
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        wren_d  = 1'b0;
        din_d   = din_q;
        set_fe  = 1'b0;
        set_ov  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        set_pe    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bitn_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rxs) begin
                    state_d = S_START;
                end
            end
            // Half a bit in: a high line here was only a glitch.
            S_START: begin
                if (tick_q == TICK_MID) begin
                    tick_d = '0;
                    bitn_d = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d    = '0;
                    par_bad_d = ^{shreg_q, rxs};
                    set_pe    = ^{shreg_q, rxs};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (!rxs) begin
                        set_fe  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad_q) begin
`else
                        begin
`endif
                            if (fifo_full) begin
                                set_ov = 1'b1;
                            end else begin
                                wren_d = 1'b1;
                                din_d  = shreg_q;
                            end
                        end
                    end
                end
            end
            // Hold off until the line returns high so a stuck-low line cannot retrigger.
            S_BREAK: begin
                tick_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        fe_d = (fe_q & ~err_clr) | set_fe;
        ov_d = (ov_q & ~err_clr) | set_ov;
`ifdef UART_RX_PARITY_EN
        pe_d = (pe_q & ~err_clr) | set_pe;
`endif
    end

    assign fifo_wren = wren_q;
    assign fifo_din  = din_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = fe_q;
    assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// tb/tb_uart_rx_fifo_writer.sv - scoreboard bench for uart_rx_fifo_writer (random + directed frames)
module tb_uart_rx_fifo_writer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 169;
`else
    localparam int LAT = 153;
`endif

    logic       clk;
    logic       reset;
    logic       line;
    logic       fifo_full;
    logic       err_clr;
    logic       fifo_wren;
    logic [7:0] fifo_din;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .line      (line),
        .fifo_full (fifo_full),
        .err_clr   (err_clr),
        .fifo_wren (fifo_wren),
        .fifo_din  (fifo_din),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    int   last_wr = 0;
    logic exp_fe = 1'b0;
    logic exp_ov = 1'b0;
    logic exp_pe = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every write must match the oldest expected byte, at the predicted cycle.
    always @(negedge clk) begin
        if (!reset && fifo_wren) begin
            wr_count++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wren: got din=0x%0h expected no write at cycle %0d", fifo_din, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("wren_data", int'(fifo_din), mon_e.data);
                chk("wren_cycle", cyc, mon_e.cyc);
                chk("busy_at_wren", int'(busy), 0);
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        line = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Caller must be at #1 after a posedge; frames chain with no gap.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par_bit);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par_bit);
`else
        if (par_bit) line = 1'b1;
`endif
        hold_bit(stop);
        line = 1'b1;
    endtask

    // Reference: decide the outcome of the whole frame, then drive it.
    task automatic frame(input logic [7:0] d, input logic stop, input logic bad_par);
        exp_t e;
        logic par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = !bad_par;
        if (bad_par) exp_pe = 1'b1;
`else
        par_ok = 1'b1;
`endif
        if (!stop) begin
            exp_fe = 1'b1;
        end else if (par_ok) begin
            if (fifo_full) begin
                exp_ov = 1'b1;
            end else begin
                e.data = int'(d);
                e.cyc  = cyc + 2 + LAT;
                sbq.push_back(e);
                last_wr = int'(d);
            end
        end
        drive_frame(d, stop, (^d) ^ bad_par);
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err"}, int'(frame_err), int'(exp_fe));
        chk({tag, "_overrun"}, int'(overrun), int'(exp_ov));
        chk({tag, "_parity_err"}, int'(parity_err), int'(exp_pe));
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        exp_pe = 1'b0;
    endtask

    initial begin
        int wc;
        int n;
        logic [7:0] rd;
        reset     = 1'b1;
        line      = 1'b1;
        fifo_full = 1'b0;
        err_clr   = 1'b0;
        idle(3);
        chk("reset_wren", int'(fifo_wren), 0);
        chk("reset_din", int'(fifo_din), 0);
        chk("reset_busy", int'(busy), 0);
        check_flags("reset");
        reset = 1'b0;
        idle(5);

        frame(8'hA5, 1'b1, 1'b0);
        idle(2);
        check_flags("a5");

        frame(8'h00, 1'b1, 1'b0);
        frame(8'hFF, 1'b1, 1'b0);
        idle(2);
        check_flags("b2b");

        line = 1'b0;
        idle(3);
        line = 1'b1;
        chk("glitch_busy_start", int'(busy), 1);
        idle(12);
        chk("glitch_busy_idle", int'(busy), 0);
        check_flags("glitch");

        wc = wr_count;
        frame(8'h55, 1'b0, 1'b0);
        line = 1'b0;
        idle(40 * CPB);
        chk("break_busy", int'(busy), 1);
        check_flags("break");
        line = 1'b1;
        idle(6);
        chk("break_exit_busy", int'(busy), 0);
        idle(30);
        chk("break_no_write", wr_count, wc);
        chk("break_no_frame", int'(busy), 0);
        clear_errors();
        check_flags("errclr_fe");

        fifo_full = 1'b1;
        frame(8'h81, 1'b1, 1'b0);
        fifo_full = 1'b0;
        idle(4);
        chk("overrun_din_hold", int'(fifo_din), last_wr);
        check_flags("overrun");
        clear_errors();
        check_flags("errclr_ov");

        fork
            drive_frame(8'hC3, 1'b1, ^8'hC3);
            begin
                idle(70);
                reset = 1'b1;
                idle(2);
                chk("midreset_busy", int'(busy), 0);
                chk("midreset_wren", int'(fifo_wren), 0);
            end
        join
        idle(2);
        reset = 1'b0;
        last_wr = 0;
        idle(3);
        chk("postreset_din", int'(fifo_din), 0);
        check_flags("postreset");
        wc = wr_count;
        frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        chk("postreset_one_write", wr_count - wc, 1);
        chk("postreset_data", int'(fifo_din), 8'h3C);

`ifdef UART_RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b0);
        idle(2);
        check_flags("par_good");
        wc = wr_count;
        frame(8'h07, 1'b1, 1'b1);
        idle(2);
        chk("par_bad_no_write", wr_count - wc, 0);
        check_flags("par_bad");
        clear_errors();
`endif

        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            frame(rd, 1'b1, 1'b0);
            fifo_full = 1'b0;
            n = $urandom_range(0, 12);
            if (n > 0) idle(n);
            check_flags("rand");
        end

        idle(200);
        chk("scoreboard_drained", sbq.size(), 0);
        chk("final_din", int'(fifo_din), last_wr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
